hdlc_rx_checker: RTL and testbench
==================================

// Module: hdlc_rx_checker
// PURPOSE
//  Synthesizable, parametrised protocol checker for the HDLC Rx path; replaces hand-written SVA checks.
//  Observes the serial Rx line and the Rx status strobes and recomputes the expected strobes itself.
//  Checks: flag/abort detection latency, abort signalling, spurious strobes, frame-length overflow.
//  Counts errors per check in saturating counters for the testbench and the on-chip debug registers.
// PARAMETERS
//  FLAG_LAT   2    cycles from last flag bit sampled to Rx_FlagDetect high (>=1)
//  ABORT_LAT  2    cycles from 7th one sampled to Rx_AbortDetect high (>=1)
//  MAX_BYTES  126  Rx_WrBuff pulses allowed per frame before Rx_Overflow is required
//  CNT_W      8    width of each error counter
//  STRICT     1    1: also flag strobes with no matching pattern (checks 0,1 reverse direction)
// PORTS
//  Clk             in   1        clock, all sampling on posedge
//  Rst             in   1        async reset, active low
//  Enable          in   1        0: checks suspended, history still shifts
//  Clear           in   1        sync clear of counters, Err_Sticky, Frame_Bytes
//  Rx              in   1        serial Rx line
//  Rx_FlagDetect   in   1        DUT strobe under check
//  Rx_AbortDetect  in   1        DUT strobe under check
//  Rx_ValidFrame   in   1        DUT frame-valid level
//  Rx_AbortSignal  in   1        DUT strobe under check
//  Rx_WrBuff       in   1        DUT byte-write strobe
//  Rx_Overflow     in   1        DUT strobe under check
//  Err_Pulse       out  4        one-cycle pulse per check: [0]flag [1]abort-det [2]abort-sig [3]overflow
//  Err_Sticky      out  1        OR of all Err_Pulse since reset/Clear
//  Err_Count       out  4*CNT_W  packed counters, check i at [i*CNT_W +: CNT_W]
//  Frame_Bytes     out  8        WrBuff pulses in current frame (saturating at 255)
// BEHAVIOUR
//  Reset (Rst=0): history, fill count, delay lines, counters, Err_*, Frame_Bytes all 0.
//  Shift hist[7:0] each edge, newest Rx in bit0; fill counter saturates at 8; no matches before 8 samples.
//  flag_m  = hist==8'b0111_1110; abort_m = hist==8'b0111_1111 (0 then seven 1s).
//  flag_m/abort_m enter FLAG_LAT/ABORT_LAT-deep delay lines; edge t match -> compared at edge t+LAT.
//  Check0: delayed flag_m && !Rx_FlagDetect -> err; STRICT: Rx_FlagDetect && !delayed flag_m -> err.
//  Check1: same rule with abort_m / Rx_AbortDetect.
//  Check2: Rx_AbortDetect && Rx_ValidFrame at edge t, Rx_AbortSignal low at t+1 -> err.
//  Check3: Frame_Bytes counts WrBuff while Rx_ValidFrame; reset to 0 on ValidFrame falling.
//   WrBuff when Frame_Bytes==MAX_BYTES arms; Rx_Overflow low on next edge -> err; overflow then clears arm.
//  Err_Pulse registered: asserted the cycle after the deciding edge, one cycle wide per event.
//  Enable=0: no Err_Pulse, counters hold; delay lines still shift so resume is aligned.
//  Counters: +1 per Err_Pulse bit, saturate at all-ones, never wrap.
//  Clear wins over simultaneous error: counters/sticky 0 that cycle, error discarded.
//  Reset mid-frame: history refills 8 samples before any new match.
// TESTING
//  Rx=0,1x6,0 then FlagDetect 2 cycles later -> Err_Pulse=0, Err_Count[0]=0.
//  Same flag, FlagDetect withheld -> Err_Pulse[0] once, Err_Count[0]=1, Err_Sticky=1.
//  ValidFrame=1, AbortDetect pulse, AbortSignal never -> Err_Count[2]=1; with AbortSignal -> 0.
//  MAX_BYTES=4: 5 WrBuff in frame, no Rx_Overflow -> Err_Count[3]=1; with overflow -> 0.
//  CNT_W=2, 5 forced flag errors -> Err_Count[0]=3 (saturated); Clear -> all 0, Err_Sticky=0.
//  STRICT=1, FlagDetect pulse on idle-ones line -> Err_Count[0]=1; STRICT=0 -> 0.

Source files
------------

// File: rtl/hdlc_rx_checker.sv
// Protocol checker for the HDLC Rx path: rebuilds the expected flag/abort/overflow strobes from the
// serial line and counts every disagreement with the DUT in saturating per-check counters.
module hdlc_rx_checker #(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned ABORT_LAT = 2,
  parameter int unsigned MAX_BYTES = 126,
  parameter int unsigned CNT_W     = 8,
  parameter bit          STRICT    = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Enable,
  input  logic               Clear,
  input  logic               Rx,
  input  logic               Rx_FlagDetect,
  input  logic               Rx_AbortDetect,
  input  logic               Rx_ValidFrame,
  input  logic               Rx_AbortSignal,
  input  logic               Rx_WrBuff,
  input  logic               Rx_Overflow,
  output logic [3:0]         Err_Pulse,
  output logic               Err_Sticky,
  output logic [4*CNT_W-1:0] Err_Count,
  output logic [7:0]         Frame_Bytes
);

  logic [7:0]           hist_q, hist_d;
  logic [3:0]           fill_q, fill_d;
  logic [FLAG_LAT-1:0]  flag_dl_q;
  logic [ABORT_LAT-1:0] abort_dl_q;
  logic                 abort_pend_q;
  logic                 vf_q;
  logic                 arm_q;
  logic                 flag_m, abort_m;
  logic                 flag_late, abort_late;
  logic                 wr_cnt;
  logic [3:0]           err_now, err_ok;

  always_comb begin
    hist_d     = {hist_q[6:0], Rx};
    fill_d     = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
    // A match needs eight genuine samples, including the one taken on this edge.
    flag_m     = (fill_d == 4'd8) && (hist_d == 8'b0111_1110);
    abort_m    = (fill_d == 4'd8) && (hist_d == 8'b0111_1111);
    flag_late  = flag_dl_q[FLAG_LAT-1];
    abort_late = abort_dl_q[ABORT_LAT-1];
    wr_cnt     = Rx_ValidFrame && Rx_WrBuff;

    err_now    = 4'b0000;
    err_now[0] = (flag_late && !Rx_FlagDetect) || (STRICT && Rx_FlagDetect && !flag_late);
    err_now[1] = (abort_late && !Rx_AbortDetect) || (STRICT && Rx_AbortDetect && !abort_late);
    err_now[2] = abort_pend_q && !Rx_AbortSignal;
    err_now[3] = arm_q && !Rx_Overflow;
    err_ok     = err_now & {4{Enable && !Clear}};
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hist_q       <= '0;
      fill_q       <= '0;
      flag_dl_q    <= '0;
      abort_dl_q   <= '0;
      abort_pend_q <= 1'b0;
      vf_q         <= 1'b0;
      arm_q        <= 1'b0;
      Err_Pulse    <= '0;
      Err_Sticky   <= 1'b0;
      Err_Count    <= '0;
      Frame_Bytes  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;

      // Delay lines keep shifting while disabled so checks resume aligned.
      flag_dl_q[0]  <= flag_m;
      abort_dl_q[0] <= abort_m;
      for (int unsigned i = 1; i < FLAG_LAT; i++) begin
        flag_dl_q[i] <= flag_dl_q[i-1];
      end
      for (int unsigned i = 1; i < ABORT_LAT; i++) begin
        abort_dl_q[i] <= abort_dl_q[i-1];
      end

      abort_pend_q <= Rx_AbortDetect && Rx_ValidFrame;
      vf_q         <= Rx_ValidFrame;
      arm_q        <= wr_cnt && (Frame_Bytes == 8'(MAX_BYTES));

      if (Clear) begin
        Frame_Bytes <= '0;
      end else if (vf_q && !Rx_ValidFrame) begin
        Frame_Bytes <= '0;
      end else if (wr_cnt && (Frame_Bytes != 8'hFF)) begin
        Frame_Bytes <= Frame_Bytes + 8'd1;
      end

      Err_Pulse <= err_ok;
      if (Clear) begin
        Err_Sticky <= 1'b0;
      end else if (|err_ok) begin
        Err_Sticky <= 1'b1;
      end

      for (int unsigned i = 0; i < 4; i++) begin
        if (Clear) begin
          Err_Count[i*CNT_W +: CNT_W] <= '0;
        end else if (err_ok[i] && (Err_Count[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          Err_Count[i*CNT_W +: CNT_W] <= Err_Count[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_checker.sv
// Directed bench for hdlc_rx_checker: two instances share stimulus, one small/strict (MAX_BYTES=4,
// CNT_W=2, STRICT=1) and one default-sized non-strict, so parameter-dependent results are compared.
module tb_hdlc_rx_checker;

  logic        Clk = 1'b0;
  logic        Rst, Enable, Clear, Rx;
  logic        Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal;
  logic        Rx_WrBuff, Rx_Overflow;
  logic [3:0]  pulse_a, pulse_b;
  logic        sticky_a, sticky_b;
  logic [7:0]  cnt_a;
  logic [31:0] cnt_b;
  logic [7:0]  bytes_a, bytes_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  hdlc_rx_checker #(
    .FLAG_LAT (2),
    .ABORT_LAT(2),
    .MAX_BYTES(4),
    .CNT_W    (2),
    .STRICT   (1'b1)
  ) u_a (
    .Clk           (Clk),
    .Rst           (Rst),
    .Enable        (Enable),
    .Clear         (Clear),
    .Rx            (Rx),
    .Rx_FlagDetect (Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_ValidFrame (Rx_ValidFrame),
    .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_WrBuff     (Rx_WrBuff),
    .Rx_Overflow   (Rx_Overflow),
    .Err_Pulse     (pulse_a),
    .Err_Sticky    (sticky_a),
    .Err_Count     (cnt_a),
    .Frame_Bytes   (bytes_a)
  );

  hdlc_rx_checker #(
    .FLAG_LAT (2),
    .ABORT_LAT(2),
    .MAX_BYTES(126),
    .CNT_W    (8),
    .STRICT   (1'b0)
  ) u_b (
    .Clk           (Clk),
    .Rst           (Rst),
    .Enable        (Enable),
    .Clear         (Clear),
    .Rx            (Rx),
    .Rx_FlagDetect (Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_ValidFrame (Rx_ValidFrame),
    .Rx_AbortSignal(Rx_AbortSignal),
    .Rx_WrBuff     (Rx_WrBuff),
    .Rx_Overflow   (Rx_Overflow),
    .Err_Pulse     (pulse_b),
    .Err_Sticky    (sticky_b),
    .Err_Count     (cnt_b),
    .Frame_Bytes   (bytes_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Flag bits MSB first; the last bit is sampled on edge t, FlagDetect is raised for edge t+2.
  task automatic send_flag(input logic det);
    logic [7:0] pat;
    pat = 8'b0111_1110;
    for (int i = 7; i >= 0; i--) begin
      Rx = pat[i];
      tick();
    end
    Rx = 1'b0;
    tick();
    Rx_FlagDetect = det;
    tick();
    Rx_FlagDetect = 1'b0;
  endtask

  task automatic run_abort(input logic sig, input logic [3:0] exp);
    logic [7:0] pat;
    pat = 8'b0111_1111;
    for (int i = 7; i >= 0; i--) begin
      Rx = pat[i];
      tick();
    end
    tick();
    Rx_AbortDetect = 1'b1;
    tick();
    Rx_AbortDetect = 1'b0;
    check("abort_det_pulse_a", 32'(pulse_a), 32'h0);
    check("abort_det_pulse_b", 32'(pulse_b), 32'h0);
    Rx_AbortSignal = sig;
    tick();
    Rx_AbortSignal = 1'b0;
    check("abort_sig_pulse_a", 32'(pulse_a), 32'(exp));
    check("abort_sig_pulse_b", 32'(pulse_b), 32'(exp));
    Rx = 1'b0;
    repeat (8) tick();
  endtask

  task automatic run_bytes(input logic ovf, input logic [3:0] exp_a);
    Rx_ValidFrame = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      Rx_WrBuff = 1'b1;
      tick();
    end
    Rx_WrBuff   = 1'b0;
    Rx_Overflow = ovf;
    tick();
    Rx_Overflow = 1'b0;
    check("ovf_pulse_a", 32'(pulse_a), 32'(exp_a));
    check("ovf_pulse_b", 32'(pulse_b), 32'h0);
    check("bytes_a", 32'(bytes_a), 32'd5);
    check("bytes_b", 32'(bytes_b), 32'd5);
    Rx_ValidFrame = 1'b0;
    tick();
    check("bytes_a_cleared", 32'(bytes_a), 32'd0);
  endtask

  initial begin
    Rst            = 1'b0;
    Enable         = 1'b1;
    Clear          = 1'b0;
    Rx             = 1'b1;
    Rx_FlagDetect  = 1'b0;
    Rx_AbortDetect = 1'b0;
    Rx_ValidFrame  = 1'b0;
    Rx_AbortSignal = 1'b0;
    Rx_WrBuff      = 1'b0;
    Rx_Overflow    = 1'b0;
    repeat (2) tick();
    check("rst_pulse_a", 32'(pulse_a), 32'h0);
    check("rst_cnt_a", 32'(cnt_a), 32'h0);
    check("rst_cnt_b", cnt_b, 32'h0);
    check("rst_sticky_a", 32'(sticky_a), 32'h0);
    check("rst_bytes_b", 32'(bytes_b), 32'h0);
    Rst = 1'b1;
    repeat (12) tick();

    // Spurious FlagDetect on an idle-ones line: only the strict instance objects.
    Rx_FlagDetect = 1'b1;
    tick();
    Rx_FlagDetect = 1'b0;
    check("strict_pulse_a", 32'(pulse_a), 32'h1);
    check("strict_pulse_b", 32'(pulse_b), 32'h0);
    tick();
    check("strict_pulse_a_end", 32'(pulse_a), 32'h0);
    check("strict_cnt_a", 32'(cnt_a[1:0]), 32'd1);
    check("strict_cnt_b", 32'(cnt_b[7:0]), 32'd0);
    check("strict_sticky_a", 32'(sticky_a), 32'h1);
    check("strict_sticky_b", 32'(sticky_b), 32'h0);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("clear1_cnt_a", 32'(cnt_a), 32'h0);
    check("clear1_sticky_a", 32'(sticky_a), 32'h0);

    Rx = 1'b0;
    repeat (10) tick();

    send_flag(1'b1);
    check("flag_ok_pulse_a", 32'(pulse_a), 32'h0);
    check("flag_ok_pulse_b", 32'(pulse_b), 32'h0);
    tick();
    check("flag_ok_cnt_a", 32'(cnt_a), 32'h0);
    check("flag_ok_cnt_b", cnt_b, 32'h0);

    send_flag(1'b0);
    check("flag_miss_pulse_a", 32'(pulse_a), 32'h1);
    check("flag_miss_pulse_b", 32'(pulse_b), 32'h1);
    tick();
    check("flag_miss_pulse_end", 32'(pulse_a), 32'h0);
    check("flag_miss_cnt_a", 32'(cnt_a[1:0]), 32'd1);
    check("flag_miss_cnt_b", 32'(cnt_b[7:0]), 32'd1);
    check("flag_miss_sticky_b", 32'(sticky_b), 32'h1);

    Enable = 1'b0;
    send_flag(1'b0);
    check("disabled_pulse_a", 32'(pulse_a), 32'h0);
    tick();
    Enable = 1'b1;
    check("disabled_cnt_a", 32'(cnt_a[1:0]), 32'd1);
    check("disabled_cnt_b", 32'(cnt_b[7:0]), 32'd1);

    Rx_ValidFrame = 1'b1;
    run_abort(1'b1, 4'h0);
    check("abort_sig_ok_cnt_b", 32'(cnt_b[23:16]), 32'd0);
    run_abort(1'b0, 4'h4);
    check("abort_sig_miss_cnt_a", 32'(cnt_a[5:4]), 32'd1);
    check("abort_sig_miss_cnt_b", 32'(cnt_b[23:16]), 32'd1);
    check("abort_det_cnt_b", 32'(cnt_b[15:8]), 32'd0);
    Rx_ValidFrame = 1'b0;
    tick();

    run_bytes(1'b1, 4'h0);
    check("ovf_ok_cnt_a", 32'(cnt_a[7:6]), 32'd0);
    run_bytes(1'b0, 4'h8);
    check("ovf_miss_cnt_a", 32'(cnt_a[7:6]), 32'd1);
    check("ovf_miss_cnt_b", 32'(cnt_b[31:24]), 32'd0);

    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_flag(1'b0);
      tick();
    end
    check("sat_cnt_a", 32'(cnt_a[1:0]), 32'd3);
    check("sat_cnt_b", 32'(cnt_b[7:0]), 32'd5);
    check("sat_sticky_a", 32'(sticky_a), 32'h1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("clear2_cnt_a", 32'(cnt_a), 32'h0);
    check("clear2_cnt_b", cnt_b, 32'h0);
    check("clear2_sticky_a", 32'(sticky_a), 32'h0);
    check("clear2_sticky_b", 32'(sticky_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
